// File: rtl/sram_byte_en_arbiter_if.sv
// Requester and SRAM-side bus for sram_byte_en_arbiter.
// slave: arbiter view; master: requesters plus SRAM (testbench/system side).
interface sram_byte_en_arbiter_if #(
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned ADDRESS_WIDTH = 7
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                     i_clear;
    logic                     o_init_done;

    logic                     i_p0_req;
    logic                     i_p0_write;
    logic [ADDRESS_WIDTH-1:0] i_p0_address;
    logic [DATA_WIDTH-1:0]    i_p0_write_data;
    logic [BE_WIDTH-1:0]      i_p0_byte_enable;
    logic                     o_p0_ack;
    logic                     o_p0_rvalid;

    logic                     i_p1_req;
    logic                     i_p1_write;
    logic [ADDRESS_WIDTH-1:0] i_p1_address;
    logic [DATA_WIDTH-1:0]    i_p1_write_data;
    logic [BE_WIDTH-1:0]      i_p1_byte_enable;
    logic                     o_p1_ack;
    logic                     o_p1_rvalid;

    logic [DATA_WIDTH-1:0]    o_read_data;

    logic [ADDRESS_WIDTH-1:0] o_sram_address;
    logic [DATA_WIDTH-1:0]    o_sram_write_data;
    logic                     o_sram_write_enable;
    logic [BE_WIDTH-1:0]      o_sram_byte_enable;
    logic [DATA_WIDTH-1:0]    i_sram_read_data;

    modport slave (
        input  i_clear,
        output o_init_done,
        input  i_p0_req, i_p0_write, i_p0_address, i_p0_write_data, i_p0_byte_enable,
        output o_p0_ack, o_p0_rvalid,
        input  i_p1_req, i_p1_write, i_p1_address, i_p1_write_data, i_p1_byte_enable,
        output o_p1_ack, o_p1_rvalid,
        output o_read_data,
        output o_sram_address, o_sram_write_data, o_sram_write_enable, o_sram_byte_enable,
        input  i_sram_read_data
    );

    modport master (
        output i_clear,
        input  o_init_done,
        output i_p0_req, i_p0_write, i_p0_address, i_p0_write_data, i_p0_byte_enable,
        input  o_p0_ack, o_p0_rvalid,
        output i_p1_req, i_p1_write, i_p1_address, i_p1_write_data, i_p1_byte_enable,
        input  o_p1_ack, o_p1_rvalid,
        input  o_read_data,
        input  o_sram_address, o_sram_write_data, o_sram_write_enable, o_sram_byte_enable,
        output i_sram_read_data
    );
endinterface

// File: rtl/sram_byte_en_arbiter.sv
// Two-port arbiter in front of a single-port byte-enable SRAM with 2-cycle read.
// Zero-fills the SRAM after reset or i_clear, then grants one access per cycle.
// Optional macro SRAM_ARB_FIXED_PRIO_EN: port 0 always wins contention
// (default: round-robin).
module sram_byte_en_arbiter #(
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned ADDRESS_WIDTH = 7
) (
    input logic                   i_clk,
    input logic                   i_reset,
    sram_byte_en_arbiter_if.slave bus
);
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] fill_count;
    logic [ADDRESS_WIDTH-1:0] fill_count_next;
    logic                     ack0;
    logic                     ack1;
    // {valid, port} per read stage; stage 1 drives the rvalid pulses
    logic [1:0]               pipe_valid;
    logic [1:0]               pipe_port;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic                     last_grant;
`endif

    // State and fill counter register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_INIT;
            fill_count <= '0;
        end else begin
            state      <= state_next;
            fill_count <= fill_count_next;
        end
    end

    // Next-state: fill runs one word per cycle, clear restarts it from zero
    always_comb begin
        state_next      = state;
        fill_count_next = fill_count;
        case (state)
            ST_INIT: begin
                if (bus.i_clear) begin
                    fill_count_next = '0;
                end else begin
                    fill_count_next = fill_count + 1'b1;
                    if (fill_count == '1) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.i_clear) begin
                    state_next      = ST_INIT;
                    fill_count_next = '0;
                end
            end
            default: begin
                state_next      = ST_INIT;
                fill_count_next = '0;
            end
        endcase
    end

    // Grant: nothing during fill or on a clear cycle; contention resolved by policy
    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (state == ST_RUN && !bus.i_clear) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            if (bus.i_p0_req) begin
                ack0 = 1'b1;
            end else if (bus.i_p1_req) begin
                ack1 = 1'b1;
            end
`else
            if (bus.i_p0_req && bus.i_p1_req) begin
                ack0 = last_grant;
                ack1 = !last_grant;
            end else if (bus.i_p0_req) begin
                ack0 = 1'b1;
            end else if (bus.i_p1_req) begin
                ack1 = 1'b1;
            end
`endif
        end
    end

`ifndef SRAM_ARB_FIXED_PRIO_EN
    // Remember the most recent winner; reset value lets port 0 win first
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_grant <= 1'b1;
        end else if (ack0 || ack1) begin
            last_grant <= ack1;
        end
    end
`endif

    // SRAM command mux: fill write, winner's fields, or idle
    always_comb begin
        bus.o_sram_address      = '0;
        bus.o_sram_write_data   = '0;
        bus.o_sram_write_enable = 1'b0;
        bus.o_sram_byte_enable  = '0;
        if (state == ST_INIT) begin
            bus.o_sram_address      = fill_count;
            bus.o_sram_write_enable = 1'b1;
            bus.o_sram_byte_enable  = '1;
        end else if (ack0) begin
            bus.o_sram_address      = bus.i_p0_address;
            bus.o_sram_write_data   = bus.i_p0_write_data;
            bus.o_sram_write_enable = bus.i_p0_write;
            bus.o_sram_byte_enable  = bus.i_p0_byte_enable;
        end else if (ack1) begin
            bus.o_sram_address      = bus.i_p1_address;
            bus.o_sram_write_data   = bus.i_p1_write_data;
            bus.o_sram_write_enable = bus.i_p1_write;
            bus.o_sram_byte_enable  = bus.i_p1_byte_enable;
        end
    end

    // Read-return pipe matching SRAM latency; keeps draining through a clear
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pipe_valid <= '0;
            pipe_port  <= '0;
        end else begin
            pipe_valid[0] <= (ack0 && !bus.i_p0_write) || (ack1 && !bus.i_p1_write);
            pipe_port[0]  <= ack1;
            pipe_valid[1] <= pipe_valid[0];
            pipe_port[1]  <= pipe_port[0];
        end
    end

    assign bus.o_p0_ack     = ack0;
    assign bus.o_p1_ack     = ack1;
    assign bus.o_p0_rvalid  = pipe_valid[1] && !pipe_port[1];
    assign bus.o_p1_rvalid  = pipe_valid[1] && pipe_port[1];
    assign bus.o_read_data  = bus.i_sram_read_data;
    assign bus.o_init_done  = (state == ST_RUN);
endmodule

// File: tb/tb_sram_byte_en_arbiter.sv
// Bench for sram_byte_en_arbiter: SRAM behavioural model, reference memory,
// read scoreboard and directed traffic. Honours SRAM_ARB_FIXED_PRIO_EN.
module tb_sram_byte_en_arbiter;
    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 4;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_byte_en_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    sram_byte_en_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic check(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // SRAM model: byte-lane write, registered read with two-cycle latency
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd1 = '0;
    logic [DW-1:0] rd2 = '0;
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = {4{32'hDEAD_0000 | i}};
    end
    always @(posedge clk) begin
        if (bus.o_sram_write_enable) begin
            for (int b = 0; b < int'(BW); b++)
                if (bus.o_sram_byte_enable[b]) mem[bus.o_sram_address][b*8 +: 8] <= bus.o_sram_write_data[b*8 +: 8];
        end
        rd1 <= mem[bus.o_sram_address];
        rd2 <= rd1;
    end
    assign bus.i_sram_read_data = rd2;

    int unsigned   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          sb [$];
    exp_t          mon_e;
    int unsigned   fill_expect = 0;
    logic          prev_init_done = 1'b0;

    task automatic apply_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        for (int b = 0; b < int'(BW); b++)
            if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    // Monitor: fill sequence, SRAM command, scoreboard push on read ack, pop on rvalid
    always @(negedge clk) begin
        if (rst) begin
            fill_expect    = 0;
            prev_init_done = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        end else begin
            check("ack_exclusive", bus.o_p0_ack & bus.o_p1_ack, 0);
            check("rvalid_exclusive", bus.o_p0_rvalid & bus.o_p1_rvalid, 0);
            if (!bus.o_init_done) begin
                check("fill_we", bus.o_sram_write_enable, 1);
                check("fill_be", bus.o_sram_byte_enable, {BW{1'b1}});
                check("fill_data", bus.o_sram_write_data, 0);
                check("fill_addr", bus.o_sram_address, fill_expect);
                check("fill_ack", bus.o_p0_ack | bus.o_p1_ack, 0);
                fill_expect++;
            end else if (!prev_init_done) begin
                check("fill_length", fill_expect, DEPTH);
            end
            if (bus.o_init_done && !bus.o_p0_ack && !bus.o_p1_ack) begin
                check("idle_we", bus.o_sram_write_enable, 0);
                check("idle_be", bus.o_sram_byte_enable, 0);
            end
            if (bus.o_p0_ack) begin
                check("sram_addr_p0", bus.o_sram_address, bus.i_p0_address);
                check("sram_we_p0", bus.o_sram_write_enable, bus.i_p0_write);
                if (bus.i_p0_write) begin
                    check("sram_wd_p0", bus.o_sram_write_data, bus.i_p0_write_data);
                    check("sram_be_p0", bus.o_sram_byte_enable, bus.i_p0_byte_enable);
                    apply_write(bus.i_p0_address, bus.i_p0_write_data, bus.i_p0_byte_enable);
                end else begin
                    sb.push_back('{port: 1'b0, data: ref_mem[bus.i_p0_address], due: cyc + 2});
                end
            end
            if (bus.o_p1_ack) begin
                check("sram_addr_p1", bus.o_sram_address, bus.i_p1_address);
                check("sram_we_p1", bus.o_sram_write_enable, bus.i_p1_write);
                if (bus.i_p1_write) begin
                    check("sram_wd_p1", bus.o_sram_write_data, bus.i_p1_write_data);
                    check("sram_be_p1", bus.o_sram_byte_enable, bus.i_p1_byte_enable);
                    apply_write(bus.i_p1_address, bus.i_p1_write_data, bus.i_p1_byte_enable);
                end else begin
                    sb.push_back('{port: 1'b1, data: ref_mem[bus.i_p1_address], due: cyc + 2});
                end
            end
            if (bus.o_p0_rvalid || bus.o_p1_rvalid) begin
                if (sb.size() == 0) begin
                    check("rvalid_spurious", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rvalid_port", bus.o_p1_rvalid, mon_e.port);
                    check("rvalid_cycle", cyc, mon_e.due);
                    check("read_data", bus.o_read_data, mon_e.data);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                check("rvalid_missing", 0, 1);
            end
            if (bus.i_clear) begin
                fill_expect = 0;
                for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
            end
            prev_init_done = bus.o_init_done;
        end
    end

    task automatic set_port(input int port, input logic req, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] be);
        if (port == 0) begin
            bus.i_p0_req = req; bus.i_p0_write = wr; bus.i_p0_address = a;
            bus.i_p0_write_data = d; bus.i_p0_byte_enable = be;
        end else begin
            bus.i_p1_req = req; bus.i_p1_write = wr; bus.i_p1_address = a;
            bus.i_p1_write_data = d; bus.i_p1_byte_enable = be;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that completes the transfer
    task automatic access(input int port, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be, output int waited);
        logic got;
        set_port(port, 1'b1, wr, a, d, be);
        waited = 0;
        forever begin
            @(negedge clk);
            got = (port == 0) ? bus.o_p0_ack : bus.o_p1_ack;
            if (got) break;
            waited++;
            if (waited > 50) begin
                check("ack_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        set_port(port, 1'b0, 1'b0, '0, '0, '0);
    endtask

    logic [DW-1:0] rnd;
    int            w;
    bit            seen;

    initial begin
        bus.i_clear = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("reset_init_done", bus.o_init_done, 0);
        check("reset_acks", {bus.o_p0_ack, bus.o_p1_ack}, 0);
        check("reset_rvalids", {bus.o_p0_rvalid, bus.o_p1_rvalid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = bus.o_init_done;
        end
        check("init_done_timeout", seen, 1);
        @(posedge clk); #1;

        // Single read of a freshly zeroed word
        access(0, 1'b0, 4'd5, '0, '0, w);
        check("p0_ack_same_cycle", w, 0);

        // Partial write then immediate read-back from port 1
        access(1, 1'b1, 4'd3, {BW{8'hAA}}, 16'h0001, w);
        check("p1_write_ack_wait", w, 0);
        access(1, 1'b0, 4'd3, '0, '0, w);
        check("p1_read_ack_wait", w, 0);
        repeat (3) @(posedge clk); #1;

        // Seed two words from port 1 so port 0 wins the first contended cycle
        rnd = {$urandom, $urandom, $urandom, $urandom};
        access(1, 1'b1, 4'd7, rnd, {BW{1'b1}}, w);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        access(1, 1'b1, 4'd9, rnd, {BW{1'b1}}, w);
        set_port(0, 1'b1, 1'b0, 4'd7, '0, '0);
        set_port(1, 1'b1, 1'b0, 4'd9, '0, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("contend_ack0", bus.o_p0_ack, FIXED_PRIO ? 1'b1 : (i % 2 == 0));
            check("contend_ack1", bus.o_p1_ack, FIXED_PRIO ? 1'b0 : (i % 2 == 1));
            @(posedge clk); #1;
        end
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk); #1;

        // Read in flight across a clear; port 1 requests during the clear cycle
        rnd = {$urandom, $urandom, $urandom, $urandom};
        access(0, 1'b1, 4'd10, rnd, {BW{1'b1}}, w);
        access(0, 1'b0, 4'd10, '0, '0, w);
        bus.i_clear = 1'b1;
        set_port(1, 1'b1, 1'b0, 4'd10, '0, '0);
        @(negedge clk);
        check("clear_cycle_no_ack", {bus.o_p0_ack, bus.o_p1_ack}, 0);
        @(posedge clk); #1;
        bus.i_clear = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            check("refill_busy", bus.o_init_done, 0);
        end
        @(negedge clk);
        check("refill_done", bus.o_init_done, 1);
        check("post_clear_ack", bus.o_p1_ack, 1);
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b0, '0, '0, '0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
